// File: rtl/transport_down_arbiter_if.sv
// ---------------------------------------------------------------------------
// transport_down_arbiter_if
// Bundles the NUM_SRC AXI-Stream source lanes and the PAICore send port that
// the downstream arbiter sits between.
//   s_axis_tdata      packed per-source frames, src i at [i*DATA_W +: DATA_W]
//   s_axis_tvalid     per-source valid
//   s_axis_tlast      per-source last beat of packet
//   s_axis_tready     per-source ready (driven by the arbiter)
//   i_send_available  PAICore can take a frame this cycle
//   o_send_valid      frame valid toward PAICore (driven by the arbiter)
//   o_send_pdata      frame data toward PAICore (driven by the arbiter)
// Modports:
//   master  the surrounding system: source FIFOs plus the PAICore sink
//   slave   the arbiter itself
// ---------------------------------------------------------------------------
interface transport_down_arbiter_if #(
  parameter int NUM_SRC = 2,
  parameter int DATA_W  = 64
);
  logic [NUM_SRC*DATA_W-1:0] s_axis_tdata;
  logic [NUM_SRC-1:0]        s_axis_tvalid;
  logic [NUM_SRC-1:0]        s_axis_tlast;
  logic [NUM_SRC-1:0]        s_axis_tready;
  logic                      i_send_available;
  logic                      o_send_valid;
  logic [DATA_W-1:0]         o_send_pdata;

  modport master (
    output s_axis_tdata,
    output s_axis_tvalid,
    output s_axis_tlast,
    output i_send_available,
    input  s_axis_tready,
    input  o_send_valid,
    input  o_send_pdata
  );

  modport slave (
    input  s_axis_tdata,
    input  s_axis_tvalid,
    input  s_axis_tlast,
    input  i_send_available,
    output s_axis_tready,
    output o_send_valid,
    output o_send_pdata
  );
endinterface

// File: rtl/transport_down_arbiter.sv
// ---------------------------------------------------------------------------
// transport_down_arbiter
// Shares the PAICore downstream send port between NUM_SRC AXI-Stream sources
// (e.g. config frames and spike/data frames). Round-robin, packet-granular:
// once a source is granted it owns the link until its tlast beat handshakes.
// Also counts delivered frames and packets.
// Ports:
//   s_axis_aclk     clock
//   s_axis_aresetn  synchronous active-low reset
//   bus             source lanes + PAICore send port (slave modport)
//   o_grant_id      currently or last granted source (holds in IDLE)
//   o_busy          1 while a packet is locked
//   o_tx_done       1-cycle pulse the cycle after a tlast beat handshakes
//   i_clear_cnt     synchronous clear of both counters (beats increments)
//   o_frame_cnt     beats delivered, wraps modulo 2^CNT_W
//   o_pkt_cnt       packets delivered, wraps modulo 2^CNT_W
// ---------------------------------------------------------------------------
module transport_down_arbiter #(
  parameter int NUM_SRC = 2,
  parameter int DATA_W  = 64,
  parameter int CNT_W   = 32
) (
  input  logic                       s_axis_aclk,
  input  logic                       s_axis_aresetn,
  transport_down_arbiter_if.slave    bus,
  output logic [$clog2(NUM_SRC)-1:0] o_grant_id,
  output logic                       o_busy,
  output logic                       o_tx_done,
  input  logic                       i_clear_cnt,
  output logic [CNT_W-1:0]           o_frame_cnt,
  output logic [CNT_W-1:0]           o_pkt_cnt
);

  localparam int GW = $clog2(NUM_SRC);

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t            state_reg, state_next;
  logic [GW-1:0]     grant_reg, grant_next;
  logic [GW-1:0]     last_grant_reg, last_grant_next;
  logic              tx_done_reg;
  logic [CNT_W-1:0]  frame_cnt_reg;
  logic [CNT_W-1:0]  pkt_cnt_reg;

  logic [DATA_W-1:0] src_data [NUM_SRC];
  logic [NUM_SRC-1:0] tready_w;

  logic              lock_fwd;
  logic              g_valid;
  logic              g_last;
  logic              hs;
  logic              hs_last;
  logic              send_valid_w;
  logic [DATA_W-1:0] send_pdata_w;

  logic              arb_any;
  logic [GW-1:0]     arb_pick;
  logic              found_hi, found_lo;
  logic [GW-1:0]     pick_hi, pick_lo;

  // Per-source unpacking and ready generation. Only the granted lane ever
  // sees ready, and only while the link is locked.
  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
      assign src_data[gi] = bus.s_axis_tdata[gi*DATA_W +: DATA_W];
      assign tready_w[gi] = lock_fwd && (grant_reg == GW'(gi)) && bus.i_send_available;
    end
  endgenerate

  // Round-robin pick: the search order last_grant+1, +2, ... (mod NUM_SRC)
  // is split into the indices above last_grant (searched first) and the
  // indices at or below it (wrap-around part). The lowest asserted index in
  // the first group wins, otherwise the lowest asserted in the second.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    pick_hi  = '0;
    pick_lo  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (bus.s_axis_tvalid[i] && (i > int'(last_grant_reg)) && !found_hi) begin
        found_hi = 1'b1;
        pick_hi  = GW'(i);
      end
      if (bus.s_axis_tvalid[i] && (i <= int'(last_grant_reg)) && !found_lo) begin
        found_lo = 1'b1;
        pick_lo  = GW'(i);
      end
    end
    arb_any  = found_hi | found_lo;
    arb_pick = found_hi ? pick_hi : pick_lo;
  end

  // Granted-lane view; meaningful only in LOCK.
  assign g_valid = bus.s_axis_tvalid[grant_reg];
  assign g_last  = bus.s_axis_tlast[grant_reg];

  // Next-state and forwarding logic.
  always_comb begin
    state_next      = state_reg;
    grant_next      = grant_reg;
    last_grant_next = last_grant_reg;
    lock_fwd        = 1'b0;
    send_valid_w    = 1'b0;
    send_pdata_w    = '0;
    hs              = 1'b0;
    hs_last         = 1'b0;
    case (state_reg)
      IDLE: begin
        // Arbitration cycle: nothing is forwarded here.
        if (arb_any) begin
          grant_next = arb_pick;
          state_next = LOCK;
        end
      end
      LOCK: begin
        lock_fwd     = 1'b1;
        send_valid_w = g_valid;
        send_pdata_w = src_data[grant_reg];
        hs           = g_valid & bus.i_send_available;
        hs_last      = hs & g_last;
        // A tvalid bubble mid-packet keeps the lock; only tlast releases it.
        if (hs_last) begin
          state_next      = IDLE;
          last_grant_next = grant_reg;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge s_axis_aclk) begin
    if (!s_axis_aresetn) begin
      state_reg      <= IDLE;
      grant_reg      <= '0;
      last_grant_reg <= GW'(NUM_SRC - 1);
      tx_done_reg    <= 1'b0;
      frame_cnt_reg  <= '0;
      pkt_cnt_reg    <= '0;
    end else begin
      state_reg      <= state_next;
      grant_reg      <= grant_next;
      last_grant_reg <= last_grant_next;
      tx_done_reg    <= hs_last;
      // Clear has priority over a same-cycle increment.
      if (i_clear_cnt) begin
        frame_cnt_reg <= '0;
        pkt_cnt_reg   <= '0;
      end else begin
        if (hs) begin
          frame_cnt_reg <= frame_cnt_reg + CNT_W'(1);
        end
        if (hs_last) begin
          pkt_cnt_reg <= pkt_cnt_reg + CNT_W'(1);
        end
      end
    end
  end

  assign bus.s_axis_tready = tready_w;
  assign bus.o_send_valid  = send_valid_w;
  assign bus.o_send_pdata  = send_pdata_w;
  assign o_grant_id        = grant_reg;
  assign o_busy            = (state_reg == LOCK);
  assign o_tx_done         = tx_done_reg;
  assign o_frame_cnt       = frame_cnt_reg;
  assign o_pkt_cnt         = pkt_cnt_reg;

endmodule
